// File: rtl/rca_seq_ctrl_if.sv
// Operand/result handshake bundle for rca_seq_ctrl.
// RCA_SEQ_OVF_EN adds the signed-overflow flag to the result side.
interface rca_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef RCA_SEQ_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef RCA_SEQ_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef RCA_SEQ_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder that drives one external 4-bit RCA slice, LSB nibble first.
// Optional macro RCA_SEQ_OVF_EN adds a registered two's-complement overflow flag (ovf).
module rca_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  rca_seq_ctrl_if.slave bus,
  output logic [3:0]  slice_a,
  output logic [3:0]  slice_b,
  output logic        slice_cin,
  input  logic [3:0]  slice_s,
  input  logic        slice_cout
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [IDXW-1:0]   idx;
  logic              carry;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [WIDTH-1:0]  sum_r;
  logic              cout_r;
  logic              out_valid_r;
  logic              last_slice;

  // Same operand signs but a result sign that differs means the signed add wrapped.
  function automatic logic sign_ovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

`ifdef RCA_SEQ_OVF_EN
  logic ovf_r;
  assign bus.ovf = ovf_r;
`endif

  assign last_slice    = (idx == IDXW'(NSLICE - 1));
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;

  always_comb begin
    slice_a   = 4'd0;
    slice_b   = 4'd0;
    slice_cin = 1'b0;
    if (state == RUN) begin
      slice_a   = a_reg[4*idx +: 4];
      slice_b   = b_reg[4*idx +: 4];
      slice_cin = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            carry <= bus.cin;
            idx   <= '0;
            state <= RUN;
`ifdef RCA_SEQ_OVF_EN
            ovf_r <= 1'b0;
`endif
          end
        end
        RUN: begin
          // The RCA is combinational, so its result for this nibble is ready this cycle.
          sum_r[4*idx +: 4] <= slice_s;
          carry             <= slice_cout;
          if (last_slice) begin
            idx         <= '0;
            cout_r      <= slice_cout;
            out_valid_r <= 1'b1;
            state       <= DONE;
`ifdef RCA_SEQ_OVF_EN
            ovf_r       <= sign_ovf(a_reg[WIDTH-1], b_reg[WIDTH-1], slice_s[3]);
`endif
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef RCA_SEQ_OVF_EN
  // Only the MSB of the operands feeds the optional overflow rule.
  logic unused_sign;
  assign unused_sign = sign_ovf(1'b0, 1'b0, 1'b0);
`endif
endmodule
